// File: rtl/spy_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spy_arbiter: round-robin sharing of the spy bus between two debug masters.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module spy_arbiter #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [3:0]  addr0,
  input  logic [3:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        busy,
  input  logic [15:0] spy_in,
  output logic [15:0] spy_out,
  output logic        dbread,
  output logic        dbwrite,
  output logic [3:0]  eadr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_ACK    = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  localparam logic [3:0] c_GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic       c_HAS_GAP  = (GAP_CYCLES > 0);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;
  logic        r_owner;
  logic        r_we;
  logic [3:0]  r_gap_cnt;
  logic        r_ack0, r_ack1, r_dbread, r_dbwrite;
  logic [15:0] r_rdata0, r_rdata1, r_spy_out;
  logic [3:0]  r_eadr;

  logic        w_any_req;
  logic        w_win;
  logic        w_we;
  logic [3:0]  w_addr;
  logic [15:0] w_wdata;

  // On a tie the requester that did not win last time takes the bus.
  assign w_any_req = req0 | req1;
  assign w_win     = (req0 & req1) ? ~r_last : req1;
  assign w_we      = w_win ? we1    : we0;
  assign w_addr    = w_win ? addr1  : addr0;
  assign w_wdata   = w_win ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_state_nxt = S_STROBE;
      S_STROBE: w_state_nxt = S_ACK;
      S_ACK:    w_state_nxt = c_HAS_GAP ? S_GAP : S_IDLE;
      S_GAP:    if (r_gap_cnt == 4'd0) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are registered: loaded at the grant edge, cleared one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_gap_cnt <= 4'd0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_rdata0  <= 16'd0;
      r_rdata1  <= 16'd0;
      r_spy_out <= 16'd0;
      r_dbread  <= 1'b0;
      r_dbwrite <= 1'b0;
      r_eadr    <= 4'd0;
    end else begin
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_spy_out <= 16'd0;
      r_dbread  <= 1'b0;
      r_dbwrite <= 1'b0;
      r_eadr    <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner   <= w_win;
            r_last    <= w_win;
            r_we      <= w_we;
            r_dbread  <= ~w_we;
            r_dbwrite <= w_we;
            r_eadr    <= w_addr;
            r_spy_out <= w_we ? w_wdata : 16'd0;
          end
        end
        S_STROBE: begin
          if (!r_we) begin
            if (r_owner) r_rdata1 <= spy_in;
            else         r_rdata0 <= spy_in;
          end
          r_ack0 <= ~r_owner;
          r_ack1 <= r_owner;
        end
        S_ACK: r_gap_cnt <= c_GAP_LOAD;
        S_GAP: if (r_gap_cnt != 4'd0) r_gap_cnt <= r_gap_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;
  assign spy_out = r_spy_out;
  assign dbread  = r_dbread;
  assign dbwrite = r_dbwrite;
  assign eadr    = r_eadr;
  assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire
